// File: rtl/load_align_unit_if.sv
// load_align_unit_if: request, data-memory read and response channels of the
// load path, bundled so the memory stage, the memory and the unit share one
// connection.
//   slave  : view of load_align_unit
//   master : view of the surrounding environment (memory stage + data memory)
// ADDR_W must match the ADDR_W of the load_align_unit it is bound to.
interface load_align_unit_if #(
   parameter int ADDR_W = 32
);
   // request channel
   logic              req_valid;
   logic              req_ready;
   logic [ADDR_W-1:0] req_addr;
   logic [5:0]        req_op;

   // data-memory read channel
   logic              mem_rd_en;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_rd_valid;
   logic [31:0]       mem_rdata;

   // response channel
   logic              rsp_valid;
   logic              rsp_ready;
   logic [31:0]       rsp_data;
   logic              rsp_exc;

   modport slave (
      input  req_valid, req_addr, req_op,
      input  mem_rd_valid, mem_rdata,
      input  rsp_ready,
      output req_ready,
      output mem_rd_en, mem_addr,
      output rsp_valid, rsp_data, rsp_exc
   );

   modport master (
      output req_valid, req_addr, req_op,
      output mem_rd_valid, mem_rdata,
      output rsp_ready,
      input  req_ready,
      input  mem_rd_en, mem_addr,
      input  rsp_valid, rsp_data, rsp_exc
   );
endinterface

// File: rtl/load_align_unit.sv
// load_align_unit: multi-cycle load path between the memory stage and data
// memory. Accepts a load request, reads one or two 32-bit little-endian words,
// then aligns, merges and sign/zero-extends the addressed field. Misaligned
// accesses that are not served and reserved opcodes return an AdEL flag
// (rsp_exc) with rsp_data forced to 0 and no memory access.
//
// Build option:
//   MISALIGN_SPLIT_EN  defined   -> any alignment is served; accesses that cross
//                                   a word boundary use a second read beat.
//                      undefined -> LW with addr[1:0]!=0 and LH/LHU with odd
//                                   address raise AdEL; one beat at most.
//
// Reset is synchronous and active-low on port 'reset'.
module load_align_unit #(
   parameter int ADDR_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   load_align_unit_if.slave bus
);

   // ---------------------------------------------------------------------
   // Opcodes and decode
   // ---------------------------------------------------------------------
   localparam logic [5:0] OP_LW  = 6'b100011;
   localparam logic [5:0] OP_LH  = 6'b100001;
   localparam logic [5:0] OP_LHU = 6'b100101;
   localparam logic [5:0] OP_LB  = 6'b100000;
   localparam logic [5:0] OP_LBU = 6'b100100;

   typedef struct packed {
      logic       ok;      // opcode is a supported load
      logic       sgn;     // sign-extend the field
      logic [2:0] nbytes;  // access size: 1, 2 or 4
   } dec_t;

   typedef enum logic [2:0] {
      IDLE,
      ISSUE0,
      WAIT0,
      ISSUE1,
      WAIT1,
      RESP
   } state_t;

   function automatic dec_t decode(input logic [5:0] op);
      dec_t d;
      d = '{ok: 1'b0, sgn: 1'b0, nbytes: 3'd0};
      case (op)
         OP_LW:   d = '{ok: 1'b1, sgn: 1'b1, nbytes: 3'd4};
         OP_LH:   d = '{ok: 1'b1, sgn: 1'b1, nbytes: 3'd2};
         OP_LHU:  d = '{ok: 1'b1, sgn: 1'b0, nbytes: 3'd2};
         OP_LB:   d = '{ok: 1'b1, sgn: 1'b1, nbytes: 3'd1};
         OP_LBU:  d = '{ok: 1'b1, sgn: 1'b0, nbytes: 3'd1};
         default: d = '{ok: 1'b0, sgn: 1'b0, nbytes: 3'd0};
      endcase
      return d;
   endfunction

   // ---------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------
   state_t            state, state_nx;
   logic [ADDR_W-1:0] addr_q;    // latched byte address
   dec_t              dec_q;     // latched decode of the opcode
   logic              exc_q;     // request ends in AdEL
   logic [31:0]       w0_q;      // first beat
   logic [23:0]       w1_q;      // second beat; only its low 3 bytes can reach the field

   // request-side decode, evaluated on the incoming request while IDLE
   dec_t              req_dec;
   logic              req_unserved;
   logic              req_exc;

   // datapath
   logic              crosses;   // access spills into the next word
   logic [ADDR_W-1:0] word_addr;
   logic [31:0]       field;
   logic [31:0]       ext;

   // internal copies of the outputs
   logic              req_ready;
   logic              mem_rd_en;
   logic [ADDR_W-1:0] mem_addr;
   logic              rsp_valid;

   // Classify the incoming request: unsupported opcode or unserved misalignment.
   always_comb begin
      // NOTE: every combinational output gets a default first, so no path through
      // the case/if below can leave a value unassigned and infer a latch.
      req_dec      = decode(bus.req_op);
      req_unserved = 1'b0;
`ifdef MISALIGN_SPLIT_EN
      req_unserved = 1'b0;
`else
      if (req_dec.nbytes == 3'd4)
         req_unserved = (bus.req_addr[1:0] != 2'b00);
      else if (req_dec.nbytes == 3'd2)
         req_unserved = bus.req_addr[0];
`endif
      req_exc = !req_dec.ok || req_unserved;
   end

   // Decide whether the latched access needs a second beat.
   always_comb begin
      crosses = 1'b0;
`ifdef MISALIGN_SPLIT_EN
      crosses = ({2'b00, addr_q[1:0]} + {1'b0, dec_q.nbytes}) > 4'd4;
`endif
   end

   assign word_addr = {addr_q[ADDR_W-1:2], 2'b00};

   // Next-state logic and handshake/memory strobes, all decoded from state.
   always_comb begin
      state_nx  = state;
      req_ready = 1'b0;
      mem_rd_en = 1'b0;
      mem_addr  = '0;
      rsp_valid = 1'b0;
      case (state)
         IDLE: begin
            req_ready = 1'b1;
            if (bus.req_valid)
               state_nx = req_exc ? RESP : ISSUE0;
         end
         ISSUE0: begin
            mem_rd_en = 1'b1;
            mem_addr  = word_addr;
            state_nx  = WAIT0;
         end
         WAIT0: begin
            if (bus.mem_rd_valid)
               state_nx = crosses ? ISSUE1 : RESP;
         end
         ISSUE1: begin
            // next word wraps modulo 2^ADDR_W
            mem_rd_en = 1'b1;
            mem_addr  = word_addr + ADDR_W'(4);
            state_nx  = WAIT1;
         end
         WAIT1: begin
            if (bus.mem_rd_valid)
               state_nx = RESP;
         end
         RESP: begin
            rsp_valid = 1'b1;
            if (bus.rsp_ready)
               state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // State register plus request latch and read-beat capture.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values, independent of statement order.
      if (!reset) begin
         // NOTE: the datapath registers are reset as well, so a response can
         // never expose data from a request dropped by reset.
         state  <= IDLE;
         addr_q <= '0;
         dec_q  <= '0;
         exc_q  <= 1'b0;
         w0_q   <= '0;
         w1_q   <= '0;
      end else begin
         state <= state_nx;
         case (state)
            IDLE: begin
               if (bus.req_valid) begin
                  addr_q <= bus.req_addr;
                  dec_q  <= req_dec;
                  exc_q  <= req_exc;
                  w0_q   <= '0;
                  w1_q   <= '0;   // single-beat loads merge against zero
               end
            end
            WAIT0: if (bus.mem_rd_valid) w0_q <= bus.mem_rdata;
            WAIT1: if (bus.mem_rd_valid) w1_q <= bus.mem_rdata[23:0];
            default: ;
         endcase
      end
   end

   // Merge the beats, shift the addressed bytes down, then extend to 32 bits.
   always_comb begin
      field = w0_q;
      case (addr_q[1:0])
         2'd0: field = w0_q;
         2'd1: field = {w1_q[7:0],  w0_q[31:8]};
         2'd2: field = {w1_q[15:0], w0_q[31:16]};
         2'd3: field = {w1_q[23:0], w0_q[31:24]};
         default: field = w0_q;
      endcase
      ext = field;
      case (dec_q.nbytes)
         3'd1:    ext = {{24{dec_q.sgn & field[7]}},  field[7:0]};
         3'd2:    ext = {{16{dec_q.sgn & field[15]}}, field[15:0]};
         default: ext = field;
      endcase
   end

   // Drive the interface; response fields are zero outside RESP and on AdEL.
   assign bus.req_ready = req_ready;
   assign bus.mem_rd_en = mem_rd_en;
   assign bus.mem_addr  = mem_addr;
   assign bus.rsp_valid = rsp_valid;
   assign bus.rsp_exc   = rsp_valid & exc_q;
   assign bus.rsp_data  = (rsp_valid && !exc_q) ? ext : 32'd0;

endmodule

// File: doc/load_align_unit.md
# load_align_unit

Multi-cycle load-path unit between the memory stage and data memory. Successor to the purely combinational load-data extender: it accepts a load request over a valid/ready handshake, issues one or two word reads to data memory, then aligns, merges and sign/zero-extends the result. Returns the result or an address-error (AdEL) flag over a second valid/ready handshake. Supports byte, halfword and word loads, signed and unsigned, with an optional split path for accesses that cross a word boundary.

## Interface
- ADDR_W, 32, byte-address width; memory is 32-bit little-endian words
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-low; clears all state when sampled low at a rising edge of clk
- req_valid  in  1  load request present
- req_ready  out  1  unit can accept a request (high only in IDLE)
- req_addr  in  ADDR_W  byte address
- req_op  in  6  load opcode: LW 100011, LH 100001, LHU 100101, LB 100000, LBU 100100
- mem_rd_en  out  1  one-cycle read strobe, one per beat
- mem_addr  out  ADDR_W  word-aligned read address; low 2 bits always 0
- mem_rd_valid  in  1  read data valid; arrives ≥1 cycle after the strobe
- mem_rdata  in  32  read word
- rsp_valid  out  1  result present
- rsp_ready  in  1  consumer accepts result
- rsp_data  out  32  extended load result; 0 when rsp_exc=1
- rsp_exc  out  1  AdEL: misaligned access that is not served, or reserved opcode

## Operation
- States: IDLE, ISSUE0, WAIT0, ISSUE1, WAIT1, RESP.
- IDLE: req_ready=1. On req_valid, latch addr and op. Size is 1, 2 or 4 bytes; a = addr[1:0].
  - Reserved opcode or unserved misalignment: next state RESP with rsp_exc=1.
  - Otherwise: next state ISSUE0.
- ISSUE0: mem_rd_en=1, mem_addr={addr[ADDR_W-1:2],2'b00}. Next state WAIT0.
- WAIT0: hold until mem_rd_valid, then capture w0.
  - If a+size>4, next state ISSUE1.
  - Otherwise, next state RESP.
- ISSUE1: mem_rd_en=1, mem_addr=word address+4, wrapping modulo 2^ADDR_W. Next state WAIT1.
- WAIT1: on mem_rd_valid, capture w1. Next state RESP.
- Merge: field = ({w1,w0} >> 8a) low size bytes. w1 is 0 when only one beat is used.
- Extend: LH/LB sign-extend from the field MSB. LHU/LBU zero-extend.
- RESP: rsp_valid=1 with stable data and exc. On rsp_ready, next state IDLE.
- mem_rd_valid outside WAIT0/WAIT1 is ignored. This includes a stale response after reset.
- Reset at any state returns to IDLE and drops any in-flight request.

## Timing
- Reset values: req_ready=1, mem_rd_en=0, mem_addr=0, rsp_valid=0, rsp_data=0, rsp_exc=0.
- Request accepted at edge k.
- Single beat:
  - mem_rd_en high during cycle k+1.
  - With memory latency 1, mem_rd_valid arrives in cycle k+2 and rsp_valid is high from cycle k+3.
  - Minimum latency, accept to rsp_valid, is 3 cycles.
- Split: 2 further cycles per extra beat. Minimum latency is 5 cycles.
- Exception: rsp_valid from cycle k+1, with no memory access.
- Backpressure: rsp_data and rsp_exc are held while rsp_valid=1 and rsp_ready=0.
- Throughput: no new request is accepted until the cycle after the RESP handshake.
- mem_rd_en is never high for two consecutive cycles.

## Configuration
- MISALIGN_SPLIT_EN defined:
  - Any alignment is served.
  - In-word misaligned LH/LHU (a=1) uses one beat.
  - Word-crossing accesses use two beats.
  - Only reserved opcodes set rsp_exc.
- MISALIGN_SPLIT_EN undefined:
  - LW with a≠0 and LH/LHU with odd a set rsp_exc=1. No read is issued.
  - ISSUE1 and WAIT1 are unreachable and may be omitted.
  - Unit is then functionally a registered natural-alignment loader.

## Test plan
- Reset low for 2 cycles mid-WAIT0, then mem_rd_valid pulses -> unit in IDLE, rsp_valid stays 0, req_ready=1.
- LB, addr 0x1003, mem_rdata 0x80FF_0102, latency 1 -> mem_addr 0x1000 in cycle k+1; rsp_data 0xFFFF_FF80 at k+3. LBU same -> 0x0000_0080.
- LH, addr 0x2002, rdata 0x9ABC_1234 -> 0xFFFF_9ABC. LHU -> 0x0000_9ABC.
- LW, addr 0x3001:
  - With MISALIGN_SPLIT_EN: w0=0x4433_2211, w1=0x8877_6655 -> reads at 0x3000 then 0x3004; rsp_data 0x5544_3322.
  - Without: rsp_exc=1, rsp_data=0 at k+1, no mem_rd_en.
- LH at addr 0xFFFF_FFFF with MISALIGN_SPLIT_EN -> second mem_addr 0x0000_0000. Result = sign-extended {w1[7:0], w0[31:24]}.
- req_op 101010 -> rsp_exc=1. Holding rsp_ready=0 for 4 cycles -> outputs stable and req_ready=0 throughout.
